// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: the FSM state encoding and the default widths.
// The register file and decode import the same defaults so that their widths line up with fetch.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int PC_WIDTH_DEF    = 10;
  localparam int INSTR_WIDTH_DEF = 9;
  localparam int OFF_WIDTH_DEF   = 6;
  localparam int CNT_WIDTH_DEF   = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; the clear wins over the increment.
// The count updates on the clock edge and holds at all-ones; there is no backpressure.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// PC and instruction fetch for the single-cycle 8-bit core: a one-cycle redirect, combinational instruction data.
// Stalls hold the PC; halting freezes the PC and counters until start_i restarts the core.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int OFF_WIDTH   = OFF_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic [PC_WIDTH-1:0]    start_addr_i,
  input  logic                   stall_i,
  input  logic                   jump_now_i,
  input  logic [OFF_WIDTH-1:0]   br_offset_i,
  input  logic                   jalr_i,
  input  logic [PC_WIDTH-1:0]    jalr_target_i,
  input  logic                   halt_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [PC_WIDTH-1:0]    link_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   instr_valid_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]   instr_cnt_o
);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   br_off_ext;
  logic                  cnt_clr;
  logic                  cyc_en;
  logic                  ins_en;

  // The offset must be narrower than the PC; the sign is replicated into the upper bits.
  assign br_off_ext = {{(PC_WIDTH - OFF_WIDTH){br_offset_i[OFF_WIDTH-1]}}, br_offset_i};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // jump_now_i is only looked at once halt, stall and jalr have all declined, so an X on it
  // outside that window never reaches the PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_clr = 1'b0;
    cyc_en  = 1'b0;
    ins_en  = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start_i) begin
          state_d = RUN;
          pc_d    = start_addr_i;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (start_i) begin
          pc_d    = start_addr_i;
          cnt_clr = 1'b1;
        end else begin
          cyc_en = 1'b1;
          ins_en = !stall_i;
          if (halt_i) begin
            state_d = HALTED;
          end else if (stall_i) begin
            pc_d = pc_q;
          end else if (jalr_i) begin
            pc_d = jalr_target_i;
          end else if (jump_now_i) begin
            pc_d = pc_q + br_off_ext;
          end else begin
            pc_d = pc_q + PC_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (cyc_en),
    .cnt_o   (cycle_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (ins_en),
    .cnt_o   (instr_cnt_o)
  );

  assign instr_valid_o = (state_q == RUN);
  assign done_o        = (state_q == HALTED);
  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign link_o        = pc_q + PC_WIDTH'(1);
  assign instr_o       = instr_valid_o ? instr_i : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random stimulus for fetch_unit, checked against a behavioural model of the PC and counters.
module tb_fetch_unit;

  localparam int PCW  = 10;
  localparam int IW   = 9;
  localparam int OW   = 6;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  localparam int PMOD = 1024;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic           clk;
  logic           reset_n;
  logic           start_i;
  logic [PCW-1:0] start_addr_i;
  logic           stall_i;
  logic           jump_now_i;
  logic [OW-1:0]  br_offset_i;
  logic           jalr_i;
  logic [PCW-1:0] jalr_target_i;
  logic           halt_i;
  logic [IW-1:0]  instr_i;
  logic [PCW-1:0] imem_addr_o;
  logic [PCW-1:0] pc_o;
  logic [PCW-1:0] link_o;
  logic [IW-1:0]  instr_o;
  logic           instr_valid_o;
  logic           done_o;
  logic [CW-1:0]  cycle_cnt_o;
  logic [CW-1:0]  instr_cnt_o;

  int n_checks = 0;
  int n_fails  = 0;
  int m_state, m_pc, m_cyc, m_ins;

  fetch_unit #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .OFF_WIDTH   (OW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (start_i),
    .start_addr_i  (start_addr_i),
    .stall_i       (stall_i),
    .jump_now_i    (jump_now_i),
    .br_offset_i   (br_offset_i),
    .jalr_i        (jalr_i),
    .jalr_target_i (jalr_target_i),
    .halt_i        (halt_i),
    .instr_i       (instr_i),
    .imem_addr_o   (imem_addr_o),
    .pc_o          (pc_o),
    .link_o        (link_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .done_o        (done_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .instr_cnt_o   (instr_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int wrap_pc(input int x);
    return ((x % PMOD) + PMOD) % PMOD;
  endfunction

  function automatic int sat_inc(input int x);
    return (x < CMAX) ? x + 1 : CMAX;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = 0;
    m_cyc   = 0;
    m_ins   = 0;
  endtask

  // One clock edge of the architectural behaviour, computed from the current inputs.
  task automatic model_step();
    int off;
    off = $signed(br_offset_i);
    if (start_i) begin
      m_state = M_RUN;
      m_pc    = int'(start_addr_i);
      m_cyc   = 0;
      m_ins   = 0;
    end else if (m_state == M_RUN) begin
      m_cyc = sat_inc(m_cyc);
      if (!stall_i) m_ins = sat_inc(m_ins);
      if (halt_i)          m_state = M_HALT;
      else if (stall_i)    m_pc = m_pc;
      else if (jalr_i)     m_pc = int'(jalr_target_i);
      else if (jump_now_i) m_pc = wrap_pc(m_pc + off);
      else                 m_pc = wrap_pc(m_pc + 1);
    end
  endtask

  task automatic check_all();
    int run;
    run = (m_state == M_RUN) ? 1 : 0;
    check_val("pc", int'(pc_o), m_pc);
    check_val("imem_addr", int'(imem_addr_o), m_pc);
    check_val("link", int'(link_o), wrap_pc(m_pc + 1));
    check_val("instr_valid", int'(instr_valid_o), run);
    check_val("done", int'(done_o), (m_state == M_HALT) ? 1 : 0);
    check_val("instr", int'(instr_o), run ? int'(instr_i) : 0);
    check_val("cycle_cnt", int'(cycle_cnt_o), m_cyc);
    check_val("instr_cnt", int'(instr_cnt_o), m_ins);
  endtask

  task automatic set_in(input logic st, input int addr, input logic stl, input logic jn,
                        input int off, input logic jl, input int tgt, input logic h);
    start_i       = st;
    start_addr_i  = PCW'(addr);
    stall_i       = stl;
    jump_now_i    = jn;
    br_offset_i   = OW'(off);
    jalr_i        = jl;
    jalr_target_i = PCW'(tgt);
    halt_i        = h;
    instr_i       = IW'($urandom);
  endtask

  task automatic set_free();
    set_in(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // Inputs are changed at the falling edge; outputs are checked at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic jump_to(input int tgt);
    set_in(1'b0, 0, 1'b0, 1'b0, 0, 1'b1, tgt, 1'b0);
    cycle();
  endtask

  task automatic restart(input int addr);
    set_in(1'b1, addr, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    set_free();
    model_reset();
    #7;
    check_all();
    check_val("rst_link", int'(link_o), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // sequential fetch from 5
    restart(5);
    check_val("start_pc", int'(pc_o), 5);
    set_free();
    repeat (3) cycle();
    check_val("seq_pc", int'(pc_o), 8);
    check_val("seq_ins", int'(instr_cnt_o), 3);
    check_val("seq_link", int'(link_o), 9);

    // branch offsets and wrap in both directions
    jump_to(20);
    set_in(1'b0, 0, 1'b0, 1'b1, -4, 1'b0, 0, 1'b0);
    cycle();
    check_val("br_back", int'(pc_o), 16);
    jump_to(1023);
    set_free();
    cycle();
    check_val("wrap_up", int'(pc_o), 0);
    jump_to(2);
    set_in(1'b0, 0, 1'b0, 1'b1, -3, 1'b0, 0, 1'b0);
    cycle();
    check_val("wrap_down", int'(pc_o), 1023);

    // jalr beats jump; stall beats both
    restart(0);
    set_in(1'b0, 0, 1'b0, 1'b1, 7, 1'b1, 300, 1'b0);
    cycle();
    check_val("pri_jalr", int'(pc_o), 300);
    set_in(1'b0, 0, 1'b1, 1'b1, 7, 1'b1, 300, 1'b0);
    cycle();
    check_val("pri_stall_pc", int'(pc_o), 300);
    check_val("pri_stall_cyc", int'(cycle_cnt_o), 2);
    check_val("pri_stall_ins", int'(instr_cnt_o), 1);

    // halt, frozen state, restart
    jump_to(40);
    set_in(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    instr_i = 9'h1A5;
    cycle();
    check_val("halt_done", int'(done_o), 1);
    check_val("halt_valid", int'(instr_valid_o), 0);
    check_val("halt_instr", int'(instr_o), 0);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, $urandom_range(0, 1023), 1'($urandom), 1'($urandom), $urandom_range(0, 63),
             1'($urandom), $urandom_range(0, 1023), 1'($urandom));
      cycle();
      check_val("halt_hold_pc", int'(pc_o), 40);
    end
    restart(0);
    check_val("restart_valid", int'(instr_valid_o), 1);
    check_val("restart_cyc", int'(cycle_cnt_o), 0);
    check_val("restart_ins", int'(instr_cnt_o), 0);

    // counter saturation
    set_free();
    repeat (20) cycle();
    check_val("sat_cyc", int'(cycle_cnt_o), CMAX);

    // asynchronous reset between edges
    jump_to(77);
    check_val("pre_async_pc", int'(pc_o), 77);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_val("async_pc", int'(pc_o), 0);
    check_val("async_valid", int'(instr_valid_o), 0);
    check_all();
    cycle();
    reset_n = 1'b1;

    // random traffic with occasional restarts and async reset pulses
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 11) == 0), $urandom_range(0, 1023),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 63),
             ($urandom_range(0, 5) == 0), $urandom_range(0, 1023),
             ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 63) == 0) begin
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        #1 reset_n = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
